// File: rtl/vinst_sched.sv
// vinst_sched: instruction scheduler for a systolic-array controller.
// Several requesters compete for a single instruction FIFO. The array
// controller reads the head entry and pops it with ird.
//
// Parameters
//   NREQ  : number of requesters, 2..4
//   DEPTH : number of FIFO entries, a power of two from 2 to 16
//
// Ports
//   clk, reset_n     : clock and asynchronous active-low reset
//   req_valid[NREQ]  : a requester has an instruction to offer
//   req_inst[NREQ]   : the instruction from each requester
//   req_ready[NREQ]  : one-hot accept, combinational
//   flush            : synchronous queue clear
//   inst             : head-of-queue instruction
//   iavail           : the queue is not empty
//   ird              : pop pulse
//   level            : current occupancy
//   underflow_err    : sticky flag, set when ird arrives while the queue is empty
//
// Build option
//   VINST_SCHED_PRIO_EN : when defined, requester 0 has strict priority and
//                         the other requesters share round-robin among themselves.

package vinst_sched_pkg;
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dst;
    logic [7:0] src;
    logic [7:0] imm;
  } sa_inst_t;
endpackage

module vinst_sched #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NREQ-1:0]                       req_valid,
  input  vinst_sched_pkg::sa_inst_t [NREQ-1:0]  req_inst,
  output logic [NREQ-1:0]                       req_ready,
  input  logic                                  flush,
  output vinst_sched_pkg::sa_inst_t             inst,
  output logic                                  iavail,
  input  logic                                  ird,
  output logic [$clog2(DEPTH):0]                level,
  output logic                                  underflow_err
);
  import vinst_sched_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef VINST_SCHED_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [RW-1:0] rr_q, rr_d;
  logic          uf_q, uf_d;
  sa_inst_t      mem_q [DEPTH];
  sa_inst_t      mem_d [DEPTH];

  logic          gnt_vld;
  logic [RW-1:0] gnt_idx;
  int unsigned   idx;
  logic          push, pop;

  // Arbiter: the search starts at rr_q and wraps modulo NREQ. In priority
  // mode, requester 0 wins outright and is left out of the rotation.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (PRIO_EN && req_valid[0]) begin
      gnt_vld = 1'b1;
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req_valid[idx[RW-1:0]] && !(PRIO_EN && idx == 0)) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[RW-1:0];
      end
    end
  end

  // Accept only when there is room. A pop in the same cycle does not free
  // an entry early, so the queue never passes an instruction straight through.
  always_comb begin
    req_ready = '0;
    if (reset_n && gnt_vld && !flush && (level_q < LW'(DEPTH))) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign push = |(req_valid & req_ready);
  assign pop  = ird && (level_q != '0);

  // Next-state logic for the queue. A flush overrides any push or pop in the
  // same cycle but leaves rr_q and uf_q unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rr_d     = rr_q;
    uf_d     = uf_q | (ird && (level_q == '0));
    if (push) begin
      rr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + RW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop) level_d = level_q + LW'(1);
      if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = req_inst[gnt_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rr_q     <= '0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rr_q     <= rr_d;
      uf_q     <= uf_d;
    end
  end

  // Storage is not reset; entries are only valid while level_q covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign inst          = mem_q[rd_ptr_q];
  assign iavail        = (level_q != '0);
  assign level         = level_q;
  assign underflow_err = uf_q;

endmodule

// File: doc/vinst_sched.md
VINST_SCHED -- requirements
Module: vinst_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of instruction requesters (2..4).
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester instruction valid.
REQ-006 SHALL have port req_inst  input  NREQ x sa_inst_t  per-requester instruction.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 SHALL have port flush  input  1  synchronous queue clear.
REQ-009 SHALL have port inst  output  sa_inst_t  head-of-queue instruction for the array controller.
REQ-010 SHALL have port iavail  output  1  queue non-empty.
REQ-011 SHALL have port ird  input  1  one-cycle pop pulse from the array controller.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port underflow_err  output  1  sticky: ird seen while empty.

Function
REQ-014 SHALL store accepted instructions in a FIFO of DEPTH entries with wrapping read/write pointers.
REQ-015 SHALL transfer from requester i in a cycle iff req_valid[i] and req_ready[i]; the instruction is written at the write pointer on that edge.
REQ-016 SHALL assert req_ready only to the granted requester, and only when level < DEPTH and flush is low; req_ready is combinational from req_valid, level, flush and arbitration state.
REQ-017 SHALL grant round-robin: search from rr_ptr upward modulo NREQ for the first asserted req_valid; no valid -> no grant.
REQ-018 SHALL set rr_ptr to (i+1) mod NREQ after a transfer from requester i; unchanged when no transfer.
REQ-019 SHALL drive inst from the entry at the read pointer; inst is don't-care when iavail is low.
REQ-020 SHALL drive iavail = (level != 0) from registered state; first pushed instruction visible one cycle after its transfer.
REQ-021 SHALL pop on ird when level != 0: read pointer advances, next entry on inst the following cycle.
REQ-022 SHALL ignore ird when level == 0 and set underflow_err, held until reset.
REQ-023 SHALL update level by +1 push only, -1 pop only, unchanged on simultaneous push and pop.
REQ-024 SHALL NOT pass through when full: at level == DEPTH req_ready is low even if ird is high that cycle.
REQ-025 SHALL on flush clear level and both pointers at the next edge, override any coincident push/pop, and leave rr_ptr and underflow_err unchanged.
REQ-026 SHALL handle read/write pointer wrap from DEPTH-1 to 0 with no loss or duplication.

Reset
REQ-027 SHALL on reset_n low immediately clear level, pointers, rr_ptr (0) and underflow_err; req_ready, iavail outputs 0.
REQ-028 SHALL discard queued instructions on reset mid-operation; storage contents need not be cleared.
REQ-029 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.

Configuration
REQ-030 SHALL, with VINST_SCHED_PRIO_EN defined, give requester 0 strict priority: granted whenever req_valid[0] is high; remaining requesters round-robin among themselves when req_valid[0] is low.
REQ-031 SHALL, without VINST_SCHED_PRIO_EN, use pure round-robin per REQ-017/018 for all requesters.

Verification
REQ-032 Reset then idle -> req_ready=0 until a valid, iavail=0, level=0, underflow_err=0.
REQ-033 Both requesters valid continuously, ird every cycle, macro off -> grants alternate 0,1,0,1; inst order matches grant order; level holds at 1.
REQ-034 Requester 1 pushes 4 instructions, no ird (DEPTH=4) -> level=4, req_ready all 0 for the 5th; one ird -> 5th accepted next cycle; 10 push/pop pairs verify wrap with correct order.
REQ-035 ird with level=0 -> level stays 0, underflow_err=1 and stays 1 across later pushes/pops until reset_n.
REQ-036 Level=3 with flush and push and ird same cycle -> level=0, iavail=0 next cycle, pushed instruction not queued, rr_ptr unchanged.
REQ-037 Macro on, both requesters valid for 4 cycles -> all 4 grants to requester 0; requester 0 drops -> requester 1 granted next cycle.
